// File: rtl/pass_sequencer.sv
// pass_sequencer: layer-level controller for the token-engine/conv-unit pass datapath.
// Latches one layer's configuration on layer_start, then walks the K-tile x D-tile loop
// (d inner, k outer), issuing one pass per tile pair and waiting for pass_done between
// passes. Pulses layer_done after the final pass.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   layer_start, layer_abort layer control (pulse / level)
//   cfg_*                    layer configuration, sampled on an accepted layer_start
//   pass_done                completion pulse from the pass datapath
//   PASS_START               one-cycle pulse per pass
//   BASE_*                   registered per-pass GLB base addresses
//   pass_flags               {accum_en, skip_en, relu_en, bias_en}
//   k_idx, d_idx             current tile indices
//   busy, layer_done         status
module pass_sequencer #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TILE_CNT_WIDTH = 8,
  parameter int unsigned FLAG_WIDTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      layer_start,
  input  logic                      layer_abort,
  input  logic [TILE_CNT_WIDTH-1:0] cfg_k_tiles,
  input  logic [TILE_CNT_WIDTH-1:0] cfg_d_tiles,
  input  logic [ADDR_WIDTH-1:0]     cfg_ifmap_base,
  input  logic [ADDR_WIDTH-1:0]     cfg_weight_base,
  input  logic [ADDR_WIDTH-1:0]     cfg_opsum_base,
  input  logic [ADDR_WIDTH-1:0]     cfg_bias_base,
  input  logic [ADDR_WIDTH-1:0]     cfg_ifmap_stride,
  input  logic [ADDR_WIDTH-1:0]     cfg_weight_stride,
  input  logic [ADDR_WIDTH-1:0]     cfg_opsum_stride,
  input  logic [ADDR_WIDTH-1:0]     cfg_bias_stride,
  input  logic                      cfg_skip_en,
  input  logic                      pass_done,
  output logic                      PASS_START,
  output logic [ADDR_WIDTH-1:0]     BASE_IFMAP,
  output logic [ADDR_WIDTH-1:0]     BASE_WEIGHT,
  output logic [ADDR_WIDTH-1:0]     BASE_OPSUM,
  output logic [ADDR_WIDTH-1:0]     BASE_BIAS,
  output logic [FLAG_WIDTH-1:0]     pass_flags,
  output logic [TILE_CNT_WIDTH-1:0] k_idx,
  output logic [TILE_CNT_WIDTH-1:0] d_idx,
  output logic                      busy,
  output logic                      layer_done
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StIssue = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StNext  = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  localparam logic [TILE_CNT_WIDTH-1:0] TileOne = TILE_CNT_WIDTH'(1);

  logic [2:0]                state_q, state_d;
  logic [TILE_CNT_WIDTH-1:0] k_q, k_d, d_q, d_d;
  logic [TILE_CNT_WIDTH-1:0] k_tiles_q, d_tiles_q;
  logic [ADDR_WIDTH-1:0]     ifmap_base_q, weight_base_q, opsum_base_q, bias_base_q;
  logic [ADDR_WIDTH-1:0]     ifmap_stride_q, weight_stride_q, opsum_stride_q, bias_stride_q;
  logic                      skip_q;
  logic [ADDR_WIDTH-1:0]     base_ifmap_q, base_weight_q, base_opsum_q, base_bias_q;
  logic [FLAG_WIDTH-1:0]     flags_q;

  logic                      latch_cfg, load_pass;

  // Source of the config used for the next pass: live inputs when starting from idle,
  // latched copies otherwise.
  logic                      use_cfg;
  logic [TILE_CNT_WIDTH-1:0] dt_src;
  logic [ADDR_WIDTH-1:0]     ib_src, wb_src, ob_src, bb_src;
  logic [ADDR_WIDTH-1:0]     is_src, ws_src, os_src, bs_src;
  logic                      skip_src;
  logic [ADDR_WIDTH-1:0]     tile_lin;
  logic [ADDR_WIDTH-1:0]     base_ifmap_d, base_weight_d, base_opsum_d, base_bias_d;
  logic [FLAG_WIDTH-1:0]     flags_d;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    d_d       = d_q;
    latch_cfg = 1'b0;
    load_pass = 1'b0;
    case (state_q)
      StIdle: begin
        if (layer_start) begin
          latch_cfg = 1'b1;
          k_d       = '0;
          d_d       = '0;
          if (cfg_k_tiles == '0 || cfg_d_tiles == '0) begin
            state_d = StDone;
          end else begin
            state_d   = StIssue;
            load_pass = 1'b1;
          end
        end
      end
      StIssue: state_d = StWait;
      StWait:  if (pass_done) state_d = StNext;
      StNext: begin
        if (d_q != d_tiles_q - TileOne) begin
          d_d       = d_q + TileOne;
          state_d   = StIssue;
          load_pass = 1'b1;
        end else if (k_q != k_tiles_q - TileOne) begin
          d_d       = '0;
          k_d       = k_q + TileOne;
          state_d   = StIssue;
          load_pass = 1'b1;
        end else begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort wins over every other transition out of a non-idle state.
    if (layer_abort && state_q != StIdle) begin
      state_d   = StIdle;
      k_d       = '0;
      d_d       = '0;
      load_pass = 1'b0;
    end
  end

  always_comb begin
    use_cfg  = (state_q == StIdle);
    dt_src   = use_cfg ? cfg_d_tiles       : d_tiles_q;
    ib_src   = use_cfg ? cfg_ifmap_base    : ifmap_base_q;
    wb_src   = use_cfg ? cfg_weight_base   : weight_base_q;
    ob_src   = use_cfg ? cfg_opsum_base    : opsum_base_q;
    bb_src   = use_cfg ? cfg_bias_base     : bias_base_q;
    is_src   = use_cfg ? cfg_ifmap_stride  : ifmap_stride_q;
    ws_src   = use_cfg ? cfg_weight_stride : weight_stride_q;
    os_src   = use_cfg ? cfg_opsum_stride  : opsum_stride_q;
    bs_src   = use_cfg ? cfg_bias_stride   : bias_stride_q;
    skip_src = use_cfg ? cfg_skip_en       : skip_q;

    tile_lin      = ADDR_WIDTH'(k_d) * ADDR_WIDTH'(dt_src) + ADDR_WIDTH'(d_d);
    base_ifmap_d  = ib_src + ADDR_WIDTH'(d_d) * is_src;
    base_weight_d = wb_src + tile_lin * ws_src;
    base_opsum_d  = ob_src + ADDR_WIDTH'(k_d) * os_src;
    base_bias_d   = bb_src + ADDR_WIDTH'(k_d) * bs_src;

    flags_d    = '0;
    flags_d[0] = (d_d == '0);
    flags_d[1] = (d_d == dt_src - TileOne);
    flags_d[2] = skip_src;
    flags_d[3] = (d_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= StIdle;
      k_q             <= '0;
      d_q             <= '0;
      k_tiles_q       <= '0;
      d_tiles_q       <= '0;
      ifmap_base_q    <= '0;
      weight_base_q   <= '0;
      opsum_base_q    <= '0;
      bias_base_q     <= '0;
      ifmap_stride_q  <= '0;
      weight_stride_q <= '0;
      opsum_stride_q  <= '0;
      bias_stride_q   <= '0;
      skip_q          <= 1'b0;
      base_ifmap_q    <= '0;
      base_weight_q   <= '0;
      base_opsum_q    <= '0;
      base_bias_q     <= '0;
      flags_q         <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      d_q     <= d_d;
      if (latch_cfg) begin
        k_tiles_q       <= cfg_k_tiles;
        d_tiles_q       <= cfg_d_tiles;
        ifmap_base_q    <= cfg_ifmap_base;
        weight_base_q   <= cfg_weight_base;
        opsum_base_q    <= cfg_opsum_base;
        bias_base_q     <= cfg_bias_base;
        ifmap_stride_q  <= cfg_ifmap_stride;
        weight_stride_q <= cfg_weight_stride;
        opsum_stride_q  <= cfg_opsum_stride;
        bias_stride_q   <= cfg_bias_stride;
        skip_q          <= cfg_skip_en;
      end
      if (load_pass) begin
        base_ifmap_q  <= base_ifmap_d;
        base_weight_q <= base_weight_d;
        base_opsum_q  <= base_opsum_d;
        base_bias_q   <= base_bias_d;
        flags_q       <= flags_d;
      end
    end
  end

  // Pulses are gated by abort so an abort landing on ISSUE/DONE suppresses them.
  assign PASS_START  = (state_q == StIssue) && !layer_abort;
  assign layer_done  = (state_q == StDone) && !layer_abort;
  assign busy        = (state_q != StIdle);
  assign BASE_IFMAP  = base_ifmap_q;
  assign BASE_WEIGHT = base_weight_q;
  assign BASE_OPSUM  = base_opsum_q;
  assign BASE_BIAS   = base_bias_q;
  assign pass_flags  = flags_q;
  assign k_idx       = k_q;
  assign d_idx       = d_q;

endmodule
